// File: rtl/booth_pkg.sv
// Shared types and helpers for the Booth multiplier arbiter: FSM states,
// radix-4 Booth digit encodings and the triplet-to-digit recoding function.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } digit_t;

  // Radix-4 Booth recoding of {b[2k+1], b[2k], b[2k-1]}.
  function automatic digit_t booth_digit(input logic [2:0] triplet);
    digit_t d;
    case (triplet)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-4 Booth step: recodes the multiplier triplet and returns the
// signed partial product d*a_ext already shifted into position 2k.
module booth_step
  import booth_pkg::*;
#(
  parameter int W  = 8,
  parameter int KW = 2
) (
  input  logic [2:0]     triplet,
  input  logic [2*W-1:0] a_ext,
  input  logic [KW-1:0]  k,
  output logic [2*W-1:0] pp
);

  logic [2*W-1:0] mag;

  // Select the signed multiple of a_ext and shift it by 2k bits.
  always_comb begin
    mag = '0;
    case (booth_digit(triplet))
      P1:      mag = a_ext;
      P2:      mag = a_ext << 1;
      M1:      mag = -a_ext;
      M2:      mag = -(a_ext << 1);
      default: mag = '0;
    endcase
    pp = mag << {k, 1'b0};
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin shared radix-4 Booth multiplier. One requester is granted per
// operation; the product is built one Booth digit per cycle and returned with
// the requester index on a registered valid/ready response channel.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. Request side: req_ready[i] is only ever raised while
// req_valid[i] is high, and requesters hold their operands until accepted.
// Response side: rsp_p/rsp_id stay constant while rsp_valid is high and
// rsp_ready is low.
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_p,
  output logic [1:0]        dbg_state
);

  localparam int KW = (W > 2) ? $clog2(W / 2) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(W / 2 - 1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic             rsp_valid_q, rsp_valid_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [W-1:0]     a_sel, b_sel;
  logic [W:0]       b_ext;
  logic [2:0]       triplet;
  logic [2*W-1:0]   a_ext;
  logic [2*W-1:0]   pp;

  // Round-robin search: first valid requester after last_grant, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDW'((int'(last_grant_q) + 1 + i) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Route the winner's operands to the capture registers.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_idx == IDW'(j)) begin
        a_sel = req_a[j*W +: W];
        b_sel = req_b[j*W +: W];
      end
    end
  end

  // Pick the current Booth triplet; b[-1] is the appended zero.
  always_comb begin
    b_ext   = {b_q, 1'b0};
    a_ext   = {{W{a_q[W-1]}}, a_q};
    triplet = '0;
    for (int s = 0; s < W / 2; s++) begin
      if (k_q == KW'(s)) triplet = b_ext[2*s +: 3];
    end
  end

  booth_step #(
    .W  (W),
    .KW (KW)
  ) u_step (
    .triplet (triplet),
    .a_ext   (a_ext),
    .k       (k_q),
    .pp      (pp)
  );

  // Next-state logic for the arbiter/FSM, accumulator and response registers.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    k_d          = k_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_valid_d  = rsp_valid_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        // Gate with reset so nobody sees an accept that cannot be latched.
        if (grant_found && !reset) begin
          req_ready[grant_idx] = 1'b1;
          a_d          = a_sel;
          b_d          = b_sel;
          rsp_id_d     = grant_idx;
          last_grant_d = grant_idx;
          acc_d        = '0;
          k_d          = '0;
          state_d      = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + pp;
        if (k_q == K_LAST) begin
          k_d         = '0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_p     = acc_q;
  assign rsp_id    = rsp_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter (NREQ=4, W=8).
module tb_booth_mul_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_p;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [IDW+2*W-1:0] exp_q[$];

  booth_mul_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Issue one request (rsp_ready assumed high) and report product, id and latency.
  task automatic run_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [2*W-1:0] p, output logic [IDW-1:0] id, output int lat);
    int t_acc;
    int n;
    p = '0; id = '0; lat = -1;
    drive_req(i, a, b);
    #1;
    n = 0;
    while (!req_ready[i] && n < 20) begin tick(); n++; end
    if (!req_ready[i]) begin
      n_vec++; n_err++;
      $display("FAIL op_accept_timeout: req %0d not accepted in %0d cycles", i, n);
      req_valid[i] = 1'b0;
      return;
    end
    t_acc = cyc;
    tick();
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    if (!rsp_valid) begin
      n_vec++; n_err++;
      $display("FAIL op_rsp_timeout: no rsp_valid for req %0d", i);
      return;
    end
    p   = rsp_p;
    id  = rsp_id;
    lat = cyc - t_acc;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_p !== 16'h0000) begin n_err++; $display("FAIL reset_rsp_p: got %h want 0000", rsp_p); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    req_valid = '0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [2*W-1:0] p;
    logic [IDW-1:0] id;
    int lat;
    run_op(2, 8'd3, 8'd5, p, id, lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL single_latency: got %0d want 5", lat); end
    n_vec++; if (p !== 16'h000F) begin n_err++; $display("FAIL single_p: got %h want 000f", p); end
    n_vec++; if (id !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", id); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_done: got %b want 0", rsp_valid); end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[6] = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'hFD};
    logic [W-1:0]   tb[6] = '{8'h80, 8'h7F, 8'hFF, 8'hB3, 8'h7F, 8'h05};
    logic [2*W-1:0] tp[6] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000, 16'h3F01, 16'hFFF1};
    logic [2*W-1:0] p;
    logic [IDW-1:0] id;
    int lat;
    for (int v = 0; v < 6; v++) begin
      run_op(v % NREQ, ta[v], tb[v], p, id, lat);
      n_vec++; if (p !== tp[v]) begin n_err++; $display("FAIL corner_p[%0d]: got %h want %h", v, p, tp[v]); end
      n_vec++; if (id !== IDW'(v % NREQ)) begin n_err++; $display("FAIL corner_id[%0d]: got %0d want %0d", v, id, v % NREQ); end
    end
  endtask

  // All four requesters continuously valid: round-robin order and issue interval.
  task automatic test_back_to_back();
    int ng = 0;
    int last_c = 0;
    int guard = 0;
    int gi;
    logic [IDW+2*W-1:0] e;
    req_valid = '0;
    rsp_ready = 1'b1;
    exp_q.delete();
    do_reset();
    for (int i = 0; i < NREQ; i++) drive_req(i, W'(i + 2), W'(i + 3));
    #1;
    while (ng < 6 && guard < 80) begin
      if (req_ready != '0) begin
        gi = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
        n_vec++; if ($countones(req_ready) != 1) begin n_err++; $display("FAIL rr_onehot: got %b", req_ready); end
        n_vec++; if (gi != ng % NREQ) begin n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", ng, gi, ng % NREQ); end
        if (ng > 0) begin
          n_vec++; if (cyc - last_c != 6) begin n_err++; $display("FAIL rr_interval[%0d]: got %0d want 6", ng, cyc - last_c); end
        end
        exp_q.push_back({IDW'(gi), 16'((gi + 2) * (gi + 3))});
        last_c = cyc;
        ng++;
      end
      if (rsp_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rr_rsp_extra: id %0d p %h", rsp_id, rsp_p); end
        else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_p} !== e) begin n_err++; $display("FAIL rr_rsp: got id %0d p %h want id %0d p %h", rsp_id, rsp_p, e[2*W +: IDW], e[2*W-1:0]); end
        end
      end
      tick();
      guard++;
    end
    n_vec++; if (ng != 6) begin n_err++; $display("FAIL rr_grant_count: got %0d want 6", ng); end
    req_valid = '0;
    exp_q.delete();
    do_reset();
  endtask

  // Consumer back-pressure: response held stable, no grants while stalled.
  task automatic test_stall();
    int n;
    req_valid = '0;
    rsp_ready = 1'b0;
    do_reset();
    drive_req(3, 8'hFB, 8'h07);
    #1;
    n = 0;
    while (!req_ready[3] && n < 20) begin tick(); n++; end
    tick();
    req_valid[3] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_rsp_timeout: got %b want 1", rsp_valid); end
    drive_req(0, 8'h11, 8'h02);
    drive_req(1, 8'h12, 8'h03);
    #1;
    for (int c = 0; c < 10; c++) begin
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", c, rsp_valid); end
      n_vec++; if (rsp_p !== 16'hFFDD) begin n_err++; $display("FAIL stall_p[%0d]: got %h want ffdd", c, rsp_p); end
      n_vec++; if (rsp_id !== 2'd3) begin n_err++; $display("FAIL stall_id[%0d]: got %0d want 3", c, rsp_id); end
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_req_ready[%0d]: got %b want 0000", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b want 0", rsp_valid); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL stall_idle: got %0d want 0", dbg_state); end
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL stall_next_grant: got %b want 0001", req_ready); end
    req_valid = '0;
    do_reset();
  endtask

  // Reset during CALC aborts the operation and restarts priority at 0.
  task automatic test_reset_mid();
    int n;
    int t_acc;
    req_valid = '0;
    rsp_ready = 1'b1;
    do_reset();
    drive_req(0, 8'h05, 8'h06);
    drive_req(1, 8'h07, 8'hF9);
    drive_req(3, 8'h02, 8'h02);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant: got %b want 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    tick();
    n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL rmid_in_calc: got %0d want 1", dbg_state); end
    reset = 1'b1;
    #1;
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rmid_abort_state: got %0d want 0", dbg_state); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rmid_ready_in_reset: got %b want 0000", req_ready); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rsp: got %b want 0", rsp_valid); end
    reset = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rmid_grant_after_reset: got %b want 0010", req_ready); end
    t_acc = cyc;
    tick();
    req_valid[1] = 1'b0;
    req_valid[3] = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    n_vec++; if (cyc - t_acc != 5) begin n_err++; $display("FAIL rmid_latency: got %0d want 5", cyc - t_acc); end
    n_vec++; if (rsp_id !== 2'd1) begin n_err++; $display("FAIL rmid_id: got %0d want 1", rsp_id); end
    n_vec++; if (rsp_p !== 16'hFFCF) begin n_err++; $display("FAIL rmid_p: got %h want ffcf", rsp_p); end
    tick();
  endtask

  // Randomised traffic checked against a scoreboard of expected responses.
  task automatic test_random();
    int acc_n = 0;
    int guard = 0;
    logic [NREQ-1:0] drop;
    logic signed [W-1:0] sa, sb;
    logic signed [2*W-1:0] sp;
    logic [IDW+2*W-1:0] e;
    req_valid = '0;
    rsp_ready = 1'b1;
    exp_q.delete();
    while ((acc_n < 300 || exp_q.size() != 0) && guard < 20000) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && acc_n < 300 && $urandom_range(0, 1) == 1)
          drive_req(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if ((req_ready & ~req_valid) != '0 || $countones(req_ready) > 1) begin
        n_vec++; n_err++;
        $display("FAIL rand_ready_legal: req_ready %b req_valid %b", req_ready, req_valid);
      end
      drop = req_ready & req_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (drop[i]) begin
          sa = req_a[i*W +: W];
          sb = req_b[i*W +: W];
          sp = sa * sb;
          exp_q.push_back({IDW'(i), sp});
          acc_n++;
        end
      end
      if (rsp_valid && rsp_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rand_rsp_extra: id %0d p %h", rsp_id, rsp_p); end
        else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_p} !== e) begin n_err++; $display("FAIL rand_rsp: got id %0d p %h want id %0d p %h", rsp_id, rsp_p, e[2*W +: IDW], e[2*W-1:0]); end
        end
      end
      tick();
      req_valid = req_valid & ~drop;
      guard++;
    end
    n_vec++;
    if (acc_n < 300 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: accepted %0d want 300, outstanding %0d want 0", acc_n, exp_q.size());
    end
    req_valid = '0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_corners();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
